// File: rtl/seq_pkg.sv
// Shared types and constants for the serial sequence path (serializer feeding seq_det).
package seq_pkg;

  typedef enum logic {IDLE, SHIFT} ser_state_t;

  localparam int SEQ_WIDTH = 16;

endpackage

// File: rtl/seq_serializer.sv
// Parallel-in/serial-out word serializer with a one-word holding buffer so
// back-to-back words stream with no idle bit between them.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = SEQ_WIDTH,
  parameter bit   LSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_t       state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [WIDTH-1:0] hold, hold_nx;
  logic             hold_full, hold_full_nx;
  logic             ser_out_nx, ser_valid_nx, word_done_nx;
  logic             xfer, ld;
  logic [WIDTH-1:0] ld_word;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  // The shift reg always holds the bits still to go, with the next one at the output end.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  assign din_ready = !hold_full;
  assign xfer      = din_valid && din_ready;
  assign busy      = (state == SHIFT) || hold_full;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    shreg_nx     = shreg;
    hold_nx      = hold;
    hold_full_nx = hold_full;
    ser_out_nx   = ser_out;
    ser_valid_nx = ser_valid;
    word_done_nx = 1'b0;
    ld           = 1'b0;
    ld_word      = din;
    case (state)
      IDLE: ld = xfer;
      SHIFT: begin
        if (cnt == LAST) begin
          // Last bit on the line: refill from hold first so word order holds.
          if (hold_full) begin
            ld           = 1'b1;
            ld_word      = hold;
            hold_full_nx = 1'b0;
          end else if (xfer) begin
            ld = 1'b1;
          end else begin
            state_nx     = IDLE;
            ser_valid_nx = 1'b0;
            ser_out_nx   = IDLE_BIT;
          end
        end else begin
          ser_out_nx   = first_bit(shreg);
          shreg_nx     = advance(shreg);
          cnt_nx       = cnt + CW'(1);
          word_done_nx = ((cnt + CW'(1)) == LAST);
          if (xfer) begin
            hold_nx      = din;
            hold_full_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (ld) begin
      state_nx     = SHIFT;
      cnt_nx       = '0;
      ser_out_nx   = first_bit(ld_word);
      shreg_nx     = advance(ld_word);
      ser_valid_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      ser_out   <= IDLE_BIT;
      ser_valid <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      shreg     <= shreg_nx;
      hold      <= hold_nx;
      hold_full <= hold_full_nx;
      ser_out   <= ser_out_nx;
      ser_valid <= ser_valid_nx;
      word_done <= word_done_nx;
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: LSB-first and MSB-first instances share one input
// stream and are checked every cycle against a bit-queue reference model.
module tb_seq_serializer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         l_ready, l_out, l_valid, l_done, l_busy;
  logic         m_ready, m_out, m_valid, m_done, m_busy;

  seq_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(l_ready),
    .ser_out(l_out), .ser_valid(l_valid), .word_done(l_done), .busy(l_busy));

  seq_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(m_ready),
    .ser_out(m_out), .ser_valid(m_valid), .word_done(m_done), .busy(m_busy));

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: every accepted word appends its bits to the queues; one bit leaves per clock.
  bit q_l[$], q_m[$], q_d[$];
  bit e_l, e_m, e_valid, e_done;
  bit accepted;

  logic [W-1:0] cap_l, cap_m;
  int n_vbits, n_done, run_len, max_run;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    q_l.delete(); q_m.delete(); q_d.delete();
    e_l = 1'b0; e_m = 1'b0; e_valid = 1'b0; e_done = 1'b0;
  endtask

  task automatic clear_stats();
    cap_l = '0; cap_m = '0; n_vbits = 0; n_done = 0; run_len = 0; max_run = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " l_out"},   32'(l_out),   32'(e_l));
    chk({tag, " m_out"},   32'(m_out),   32'(e_m));
    chk({tag, " l_valid"}, 32'(l_valid), 32'(e_valid));
    chk({tag, " m_valid"}, 32'(m_valid), 32'(e_valid));
    chk({tag, " l_done"},  32'(l_done),  32'(e_done));
    chk({tag, " m_done"},  32'(m_done),  32'(e_done));
    chk({tag, " l_busy"},  32'(l_busy),  32'(e_valid));
    chk({tag, " m_busy"},  32'(m_busy),  32'(e_valid));
  endtask

  // One clock: drive after the falling edge, model at the rising edge, check at the next falling edge.
  task automatic step(input bit v, input logic [W-1:0] w);
    bit rdy;
    din = w; din_valid = v;
    #1;
    rdy = (q_l.size() < W);
    chk("din_ready l", 32'(l_ready), 32'(rdy));
    chk("din_ready m", 32'(m_ready), 32'(rdy));
    accepted = v && rst && rdy;
    @(posedge clk);
    if (rst) begin
      if (accepted)
        for (int i = 0; i < W; i++) begin
          q_l.push_back(w[i]);
          q_m.push_back(w[W-1-i]);
          q_d.push_back(i == W-1);
        end
      if (q_l.size() > 0) begin
        e_l = q_l.pop_front(); e_m = q_m.pop_front(); e_done = q_d.pop_front(); e_valid = 1'b1;
      end else begin
        e_l = 1'b0; e_m = 1'b0; e_done = 1'b0; e_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_outputs("cycle");
    if (l_valid) begin
      cap_l = {l_out, cap_l[W-1:1]};
      cap_m = {cap_m[W-2:0], m_out};
      n_vbits++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (l_done) n_done++;
  endtask

  task automatic send(input logic [W-1:0] w);
    int k;
    k = 0;
    accepted = 1'b0;
    while (!accepted && k < 40) begin
      step(1'b1, w);
      k++;
    end
    if (!accepted) chk("send timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom));
  endtask

  // Asynchronous reset dropped mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset(input int cycles);
    #2 rst = 1'b0;
    #1;
    clear_model();
    check_outputs("async reset");
    @(negedge clk);
    for (int i = 0; i < cycles; i++) step(1'b1, W'($urandom));
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; din = '0; din_valid = 1'b0;
    clear_model();
    clear_stats();
    @(negedge clk);

    // Reset held with valid asserted: nothing accepted.
    for (int i = 0; i < 3; i++) step(1'b1, 16'hBEEF);
    rst = 1'b1;
    idle(2);

    // Single word, both bit orders.
    clear_stats();
    send(16'hABCD);
    idle(W + 3);
    chk("abcd lsb bits", 32'(cap_l), 32'h0000ABCD);
    chk("abcd msb bits", 32'(cap_m), 32'h0000ABCD);
    chk("abcd nbits",    32'(n_vbits), 32'd16);
    chk("abcd ndone",    32'(n_done),  32'd1);

    // Back-to-back with no gap.
    clear_stats();
    send(16'hABCD);
    send(16'h1234);
    idle(2 * W + 3);
    chk("b2b nbits",   32'(n_vbits), 32'd32);
    chk("b2b maxrun",  32'(max_run), 32'd32);
    chk("b2b ndone",   32'(n_done),  32'd2);
    chk("b2b last lsb", 32'(cap_l), 32'h00001234);

    // Reset in the middle of a word, then a clean restart.
    send(16'hFFFF);
    idle(5);
    async_reset(2);
    clear_stats();
    send(16'h0001);
    chk("post-reset first bit", 32'(l_out), 32'd1);
    idle(W + 2);
    chk("post-reset word", 32'(cap_l), 32'h00000001);
    chk("post-reset nbits", 32'(n_vbits), 32'd16);

    // MSB-first corner word.
    clear_stats();
    send(16'h8001);
    chk("msb first bit", 32'(m_out), 32'd1);
    idle(W + 2);
    chk("8001 msb bits", 32'(cap_m), 32'h00008001);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if (i == 250 || i == 470) async_reset(1 + int'($urandom_range(0, 2)));
      else step(($urandom % 4) != 0, W'($urandom));
    end
    idle(2 * W + 4);
    chk("drained", 32'(l_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
